// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module   : sync_fifo_pkg
// Brief    : Shared constants and helpers for the synchronous FIFO family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

   // Read-port modes: combinational head (first-word-fall-through) or output flop
   localparam int FIFO_OUT_COMB = 0;
   localparam int FIFO_OUT_REG  = 1;

   // Advance a pointer and wrap explicitly at depth-1, so any depth works
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module   : sync_fifo_mem
// Brief    : DEPTH x WIDTH register array, one write port, one asynchronous
//            read port, no reset (contents are don't-care until written).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the addressed entry; storage is deliberately left without reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_hs.sv
// ============================================================================
// Module   : sync_fifo_hs
// Brief    : Single-clock valid/ready FIFO, any depth >= 2, optional output
//            register, programmable almost-full/empty, level output, flush.
//            Define SYNC_FIFO_HS_ERR_FLAGS_EN to enable the sticky
//            overflow/underflow flags (otherwise they read 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_hs
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int WIDTH   = 8,
   parameter int OUT_REG = FIFO_OUT_COMB,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   input  logic             flush,
   input  logic [CNT_W-1:0] afull_thr,
   input  logic [CNT_W-1:0] aempty_thr,
   output logic [CNT_W-1:0] level,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] mem_rd_data;
   logic             push, pop, st_rd;

   // Status is derived only from the registered level: no rd_ready -> wr_ready path
   assign full         = (level_q == CNT_W'(DEPTH));
   assign empty        = (level_q == '0);
   assign wr_ready     = !full;
   assign almost_full  = (level_q >= afull_thr);
   assign almost_empty = (level_q <= aempty_thr);
   assign level        = level_q;
   assign push         = wr_valid & wr_ready;
   assign pop          = rd_valid & rd_ready;

   sync_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
      .clk     (clk),
      .wr_en   (push & !flush),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   generate
      if (OUT_REG == FIFO_OUT_REG) begin : g_out_reg
         logic             ov_q, ov_d;
         logic [WIDTH-1:0] od_q, od_d;
         logic [CNT_W-1:0] st_cnt;
         logic             load;

         // level includes the flop, so storage holds level minus the flop's entry
         assign st_cnt = level_q - CNT_W'(ov_q);
         assign load   = (!ov_q || pop) && (st_cnt != '0);
         assign st_rd  = load;

         // Refill the output flop from the storage head when it frees up
         always_comb begin
            ov_d = ov_q;
            od_d = od_q;
            if (flush) begin
               ov_d = 1'b0;
            end else if (load) begin
               ov_d = 1'b1;
               od_d = mem_rd_data;
            end else if (pop) begin
               ov_d = 1'b0;
            end
         end

         // Output flop state, cleared asynchronously
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               ov_q <= 1'b0;
               od_q <= '0;
            end else begin
               ov_q <= ov_d;
               od_q <= od_d;
            end
         end

         assign rd_valid = ov_q;
         assign rd_data  = od_q;
      end else begin : g_out_comb
         assign st_rd    = pop;
         assign rd_valid = !empty;
         assign rd_data  = mem_rd_data;
      end
   endgenerate

   // Pointer and level update; flush discards any same-cycle push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push)  wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
         if (st_rd) rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
         if (push && !pop)      level_d = level_q + CNT_W'(1);
         else if (pop && !push) level_d = level_q - CNT_W'(1);
      end
   end

   // Pointer and level registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

`ifdef SYNC_FIFO_HS_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   // Sticky protocol-error flags; clear wins over a same-cycle set
   always_comb begin
      ovf_d = ovf_q | (wr_valid & !wr_ready);
      udf_d = udf_q | (rd_ready & !rd_valid);
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   // Error flag registers, untouched by flush
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

`default_nettype wire
